result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer.sv | 129 ++++++++++++
 tb/tb_result_serializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// Result serializer: captures a 256-bit accumulator block on the rising edge of
// acc_done and emits it as 16 addressed 16-bit words over a valid/ready port.
// One block is active and one more can wait in a pending slot; a third is dropped.
module result_serializer #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              acc_done,
  input  logic [255:0]      acc_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              block_done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  typedef enum logic {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [3:0]          word_idx_q, word_idx_d;
  logic [ADDR_W-1:0]   block_idx_q, block_idx_d;
  logic                pend_valid_q, pend_valid_d;
  logic                overflow_q, overflow_d;
  logic [255:0]        active_q, active_d;
  logic [255:0]        pend_q, pend_d;
  logic                acc_done_q;
  // Cleared while acc_done is high at reset so a level held across reset is
  // not mistaken for a new edge; set once acc_done has been seen low.
  logic                armed_q;

  logic send, capture, xfer, last_xfer;

  assign send      = (state_q == StSend);
  assign capture   = acc_done & ~acc_done_q & armed_q;
  assign xfer      = send & out_ready;
  assign last_xfer = xfer & (word_idx_q == 4'd15);

  // Output port view of the current state; word k sits at [255-16k -: 16].
  assign out_valid  = send;
  assign busy       = send;
  assign block_done = last_xfer;
  assign overflow   = overflow_q;
  assign out_data   = send ? active_q[{~word_idx_q, 4'b0000} +: 16] : 16'h0000;
  assign out_addr   = BaseAddr + (block_idx_q << 4) + ADDR_W'(word_idx_q);

  // Next-state: word sequencing, pending hand-over and overflow detection.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    block_idx_d  = block_idx_q;
    pend_valid_d = pend_valid_q;
    overflow_d   = overflow_q;
    active_d     = active_q;
    pend_d       = pend_q;

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          active_d   = acc_data;
          word_idx_d = 4'd0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          word_idx_d = word_idx_q + 4'd1;
        end
        if (last_xfer) begin
          block_idx_d = block_idx_q + ADDR_W'(1);
          if (pend_valid_q) begin
            // Pending slot frees this cycle, so a coinciding capture refills it.
            active_d = pend_q;
            if (capture) begin
              pend_d = acc_data;
            end else begin
              pend_valid_d = 1'b0;
            end
          end else if (capture) begin
            active_d = acc_data;
          end else begin
            state_d = StIdle;
          end
        end else if (capture) begin
          if (pend_valid_q) begin
            overflow_d = 1'b1;
          end else begin
            pend_d       = acc_data;
            pend_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state with synchronous reset; reset wins over any capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      word_idx_q   <= 4'd0;
      block_idx_q  <= '0;
      pend_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      acc_done_q   <= 1'b0;
      armed_q      <= ~acc_done;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      block_idx_q  <= block_idx_d;
      pend_valid_q <= pend_valid_d;
      overflow_q   <= overflow_d;
      acc_done_q   <= acc_done;
      armed_q      <= armed_q | ~acc_done;
    end
  end

  // Block storage needs no reset; it is only observed while sending.
  always_ff @(posedge clock) begin
    active_q <= active_d;
    pend_q   <= pend_d;
  end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: two instances (base 0x00 and base 0xF8) share
// stimulus; a scoreboard queue holds every expected word with both addresses.
module tb_result_serializer;

  logic         clock, reset, acc_done, out_ready;
  logic [255:0] acc_data;

  logic        valid_a, busy_a, bd_a, ovf_a;
  logic [15:0] data_a;
  logic [7:0]  addr_a;
  logic        valid_b, busy_b, bd_b, ovf_b;
  logic [15:0] data_b;
  logic [7:0]  addr_b;

  result_serializer #(.ADDR_W(8), .BASE_ADDR(0)) u_dut_a (
    .clock(clock), .reset(reset), .acc_done(acc_done), .acc_data(acc_data),
    .out_ready(out_ready), .out_valid(valid_a), .out_data(data_a), .out_addr(addr_a),
    .busy(busy_a), .block_done(bd_a), .overflow(ovf_a)
  );

  result_serializer #(.ADDR_W(8), .BASE_ADDR(32'hF8)) u_dut_b (
    .clock(clock), .reset(reset), .acc_done(acc_done), .acc_data(acc_data),
    .out_ready(out_ready), .out_valid(valid_b), .out_data(data_b), .out_addr(addr_b),
    .busy(busy_b), .block_done(bd_b), .overflow(ovf_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  addr;
    logic        last;
  } exp_t;

  typedef struct {
    int unsigned mode;       // 0: ready=1, 1: ready 1,0,0,..., 2: ready=0 for 20 cycles
    int unsigned n;          // number of acc_done pulses
    int unsigned t0, t1, t2; // pulse start cycles
    int unsigned hold;       // cycles acc_done stays high per pulse
    int unsigned exp_xfers;
    bit          exp_ovf;
  } scen_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          xfers    = 0;
  bit          mon_en   = 0;
  bit          m_prev   = 0;
  bit          m_armed  = 1;
  bit          m_ov     = 0;
  int unsigned m_blk    = 0;
  bit          stalled  = 0;
  logic [15:0] st_data;
  logic [7:0]  st_addr;
  int unsigned mode     = 0;
  int unsigned rel      = 0;
  logic [15:0] seed     = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: one negedge per cycle, between the edges that sample the inputs.
  always @(negedge clock) begin : monitor
    exp_t       e;
    logic [7:0] ab;
    logic       ev;
    if (mon_en) begin
      check("out_valid", valid_a, sb.size() > 0);
      check("out_valid_b", valid_b, sb.size() > 0);
      check("busy", busy_a, sb.size() > 0);
      check("overflow", ovf_a, m_ov);
      check("overflow_b", ovf_b, m_ov);
      if (!valid_a) check("idle_data", data_a, 0);
      if (stalled && valid_a) begin
        check("hold_data", data_a, st_data);
        check("hold_addr", addr_a, st_addr);
      end
      if (reset) begin
        sb.delete();
        m_blk   = 0;
        m_ov    = 0;
        m_prev  = 0;
        m_armed = !acc_done;
        stalled = 0;
      end else begin
        ev = valid_a && out_ready;
        check("block_done", bd_a, ev && ((sb.size() > 0) ? sb[0].last : 1'b0));
        if (ev) begin
          if (sb.size() == 0) begin
            check("unexpected_word", valid_a, 0);
          end else begin
            e  = sb.pop_front();
            ab = e.addr + 8'hF8;
            check("word_data", data_a, e.data);
            check("word_addr", addr_a, e.addr);
            check("word_data_b", data_b, e.data);
            check("word_addr_b", addr_b, ab);
            xfers++;
          end
        end
        stalled = valid_a && !out_ready;
        st_data = data_a;
        st_addr = addr_a;
        if (acc_done && !m_prev && m_armed) begin
          if ((sb.size() + 15) / 16 < 2) begin
            for (int k = 0; k < 16; k++) begin
              e.data = acc_data[255-16*k -: 16];
              e.addr = 8'(16 * m_blk + k);
              e.last = (k == 15);
              sb.push_back(e);
            end
            m_blk++;
          end else begin
            m_ov = 1;
          end
        end
        if (!acc_done) m_armed = 1;
        m_prev = acc_done;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rel % 3 == 0);
      default: out_ready = (rel >= 20);
    endcase
    rel++;
  endtask

  task automatic make_block();
    for (int k = 0; k < 16; k++) acc_data[255-16*k -: 16] = seed + 16'(k + 1);
    seed = seed + 16'd16;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    acc_done = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_block_done", bd_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_data", data_a, 0);
    check("rst_addr", addr_a, 8'h00);
    check("rst_addr_b", addr_b, 8'hF8);
  endtask

  task automatic wait_idle();
    acc_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (sb.size() == 0 && valid_a == 1'b0) break;
      step();
    end
    check("drain_left", sb.size(), 0);
    check("drain_valid", valid_a, 0);
  endtask

  task automatic run_scen(input scen_t s, input int idx);
    int unsigned t[3];
    int unsigned last;
    t[0] = s.t0;
    t[1] = s.t1;
    t[2] = s.t2;
    last = 0;
    for (int i = 0; i < int'(s.n); i++) if (t[i] + s.hold > last) last = t[i] + s.hold;
    mode  = s.mode;
    rel   = 0;
    xfers = 0;
    for (int unsigned c = 0; c <= last; c++) begin
      step();
      acc_done = 1'b0;
      for (int i = 0; i < int'(s.n); i++) begin
        if (c >= t[i] && c < t[i] + s.hold) acc_done = 1'b1;
        if (c == t[i]) make_block();
        else if (c == t[i] + 1) acc_data = {8{$urandom}};
      end
    end
    wait_idle();
    check($sformatf("scen%0d_words", idx), xfers, s.exp_xfers);
    check($sformatf("scen%0d_overflow", idx), ovf_a, s.exp_ovf);
  endtask

  scen_t tbl[9];

  initial begin
    tbl[0] = '{0, 1, 0, 0, 0, 1, 16, 1'b0};   // single block
    tbl[1] = '{1, 1, 0, 0, 0, 1, 16, 1'b0};   // backpressure 1,0,0
    tbl[2] = '{0, 2, 0, 5, 0, 1, 32, 1'b0};   // back-to-back, no bubble
    tbl[3] = '{2, 3, 0, 3, 6, 1, 32, 1'b1};   // third block dropped
    tbl[4] = '{0, 1, 0, 0, 0, 40, 16, 1'b0};  // level held 40 cycles
    tbl[5] = '{0, 2, 0, 16, 0, 1, 32, 1'b0};  // capture on word 15, pending empty
    tbl[6] = '{0, 3, 0, 3, 16, 1, 48, 1'b0};  // capture on word 15, pending full
    tbl[7] = '{0, 3, 0, 3, 15, 1, 32, 1'b1};  // one cycle early: dropped
    tbl[8] = '{1, 2, 0, 10, 0, 1, 32, 1'b0};  // backpressure with pending

    reset     = 1'b1;
    acc_done  = 1'b0;
    out_ready = 1'b0;
    acc_data  = '0;
    do_reset();
    mon_en = 1;

    for (int i = 0; i < 9; i++) begin
      run_scen(tbl[i], i);
      do_reset();
    end

    // Reset at word 7 with a block pending, then restart from block 0.
    mode  = 0;
    rel   = 0;
    xfers = 0;
    step(); acc_done = 1'b1; make_block();
    step(); acc_done = 1'b0; acc_data = {8{$urandom}};
    step();
    step(); acc_done = 1'b1; make_block();
    step(); acc_done = 1'b0;
    for (int i = 0; i < 40 && xfers < 7; i++) step();
    check("h1_reach_word7", xfers, 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    xfers = 0;
    check("h1_valid", valid_a, 0);
    check("h1_busy", busy_a, 0);
    check("h1_addr", addr_a, 8'h00);
    check("h1_addr_b", addr_b, 8'hF8);
    step(); acc_done = 1'b1; make_block();
    step(); acc_done = 1'b0;
    wait_idle();
    check("h1_words", xfers, 16);

    // acc_done held high across reset release produces no block.
    acc_done = 1'b1;
    reset    = 1'b1;
    step();
    step();
    reset = 1'b0;
    xfers = 0;
    repeat (10) step();
    check("h2_no_event", xfers, 0);
    check("h2_idle", valid_a, 0);
    acc_done = 1'b0;
    step(); acc_done = 1'b1; make_block();
    step(); acc_done = 1'b0;
    wait_idle();
    check("h2_words", xfers, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
